ddr_tx_lanes: RTL and testbench

//  Multi-lane SDR-to-DDR transmit front end. Accepts 2*LANES-bit SDR words on a

---
 rtl/ddr_tx_pkg.sv | 28 ++
 rtl/ddr_tx_fifo.sv | 51 +++++
 rtl/ddr_tx_lanes.sv | 120 ++++++++++++
 tb/tb_ddr_tx_lanes.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_tx_pkg.sv
// Shared types and constants for the multi-lane SDR-to-DDR transmit block.
// Holds the state encoding, default lane pairs and a pair-replication helper.
package ddr_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRAIN  = 2'd1,
        STREAM = 2'd2
    } state_t;

    localparam logic [1:0] IDLE_PAIR  = 2'b00;
    localparam logic [1:0] TRAIN_PAIR = 2'b01;
    localparam int         MAX_LANES  = 16;

    // Replicates a {fall,rise} pair across the low 'lanes' lanes.
    function automatic logic [2*MAX_LANES-1:0] rep_pair(
        input logic [1:0] pair,
        input int         lanes
    );
        logic [2*MAX_LANES-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < lanes) v[2*i +: 2] = pair;
        end
        return v;
    endfunction

endpackage

// File: rtl/ddr_tx_fifo.sv
// Synchronous FIFO buffering SDR words ahead of the DDR lanes.
// Ports: clk_buf_i/reset_n_buf, i_push/i_wdata, i_pop/o_rdata (show-ahead),
//        o_full, o_empty, o_level (exact occupancy).
module ddr_tx_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_buf_i,
    input  logic             reset_n_buf,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [LW-1:0]    o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr;
    logic             w_rd;

    // The extra MSB on each pointer separates full from empty.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level = LW'(r_wr_ptr - r_rd_ptr);
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    assign w_wr = i_push && !o_full;
    assign w_rd = i_pop && !o_empty;

    always_ff @(posedge clk_buf_i or negedge reset_n_buf) begin
        if (!reset_n_buf) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_buf_i) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/ddr_tx_lanes.sv
// Multi-lane SDR-to-DDR transmit front end: FIFO, mode FSM, output register.
// Ports: clk_buf_i/reset_n_buf, enable_buf, train_en, in_valid/in_ready/in_data,
//        ddr_d/ddr_en to the pad cells, fifo_level, underflow, training.
module ddr_tx_lanes
    import ddr_tx_pkg::*;
#(
    parameter int         LANES      = 4,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [1:0] IDLE_WORD  = IDLE_PAIR,
    parameter logic [1:0] TRAIN_WORD = TRAIN_PAIR
) (
    input  logic                             clk_buf_i,
    input  logic                             reset_n_buf,
    input  logic                             enable_buf,
    input  logic                             train_en,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [2*LANES-1:0]               in_data,
    output logic [2*LANES-1:0]               ddr_d,
    output logic                             ddr_en,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             underflow,
    output logic                             training
);

    localparam int W = 2 * LANES;
    localparam logic [W-1:0] IDLE_VEC  = W'(rep_pair(IDLE_WORD, LANES));
    localparam logic [W-1:0] TRAIN_VEC = W'(rep_pair(TRAIN_WORD, LANES));

    state_t         r_state;
    state_t         w_nxt;
    logic           r_empty_seen;
    logic           r_rdy;
    logic [W-1:0]   r_ddr_d;
    logic           r_ddr_en;
    logic           r_underflow;
    logic [W-1:0]   w_rdata;
    logic [W-1:0]   w_ddr_d_nxt;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;

    // r_rdy keeps in_ready low while reset is held.
    assign in_ready   = r_rdy && !w_full;
    assign w_push     = in_valid && in_ready;
    assign ddr_d      = r_ddr_d;
    assign ddr_en     = r_ddr_en;
    assign underflow  = r_underflow;
    assign training   = (r_state == TRAIN);

    ddr_tx_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_buf_i   (clk_buf_i),
        .reset_n_buf (reset_n_buf),
        .i_push      (w_push),
        .i_wdata     (in_data),
        .i_pop       (w_pop),
        .o_rdata     (w_rdata),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (fifo_level)
    );

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (train_en)      w_nxt = TRAIN;
                else if (!w_empty) w_nxt = STREAM;
            end
            TRAIN: begin
                if (!train_en) w_nxt = w_empty ? IDLE : STREAM;
            end
            STREAM: begin
                if (train_en)                     w_nxt = TRAIN;
                else if (w_empty && r_empty_seen) w_nxt = IDLE;
            end
            default: w_nxt = IDLE;
        endcase
        if (!enable_buf) w_nxt = r_state;
    end

    // The output register captures what the state being entered drives,
    // so a word entering STREAM from IDLE is popped on that same edge.
    assign w_pop = enable_buf && (w_nxt == STREAM) && !w_empty;

    always_comb begin
        w_ddr_d_nxt = IDLE_VEC;
        unique case (1'b1)
            w_pop:            w_ddr_d_nxt = w_rdata;
            (w_nxt == TRAIN): w_ddr_d_nxt = TRAIN_VEC;
            default:          w_ddr_d_nxt = IDLE_VEC;
        endcase
    end

    always_ff @(posedge clk_buf_i or negedge reset_n_buf) begin
        if (!reset_n_buf) begin
            r_state      <= IDLE;
            r_empty_seen <= 1'b0;
            r_rdy        <= 1'b0;
            r_ddr_d      <= '0;
            r_ddr_en     <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
            if (enable_buf) begin
                r_state      <= w_nxt;
                r_ddr_d      <= w_ddr_d_nxt;
                r_ddr_en     <= (w_nxt != IDLE);
                r_empty_seen <= (r_state == STREAM) &&
                                (w_nxt == STREAM) && w_empty;
                if ((r_state == STREAM) && w_empty) r_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_tx_lanes.sv
// Directed self-checking bench for ddr_tx_lanes (LANES=4, FIFO_DEPTH=8).
// Ports: none.
module tb_ddr_tx_lanes;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       tr;
    logic       iv;
    logic       rdy;
    logic [7:0] id;
    logic [7:0] dd;
    logic       de;
    logic [3:0] lvl;
    logic       uf;
    logic       trn;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ddr_tx_lanes #(.LANES(4), .FIFO_DEPTH(8)) dut (
        .clk_buf_i   (clk),
        .reset_n_buf (rst_n),
        .enable_buf  (en),
        .train_en    (tr),
        .in_valid    (iv),
        .in_ready    (rdy),
        .in_data     (id),
        .ddr_d       (dd),
        .ddr_en      (de),
        .fifo_level  (lvl),
        .underflow   (uf),
        .training    (trn)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        iv = 1'b0;
        tr = 1'b0;
        en = 1'b0;
        id = 8'h00;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        tr = 1'b0;
        iv = 1'b0;
        id = 8'h00;
        #1;
        chk("rst_d", dd, 0);
        chk("rst_en", de, 0);
        chk("rst_rdy", rdy, 0);
        chk("rst_lvl", lvl, 0);
        chk("rst_uf", uf, 0);
        chk("rst_trn", trn, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rdy_up", rdy, 1);

        // Latency and order
        en = 1'b1;
        iv = 1'b1; id = 8'hA5; tick();
        chk("lat_lvl0", lvl, 1);
        chk("lat_en0", de, 0);
        id = 8'h3C; tick();
        chk("lat_d0", dd, 8'hA5);
        chk("lat_en1", de, 1);
        chk("lat_lvl1", lvl, 1);
        id = 8'hFF; tick();
        chk("lat_d1", dd, 8'h3C);
        iv = 1'b0; tick();
        chk("lat_d2", dd, 8'hFF);
        chk("lat_lvl2", lvl, 0);
        chk("lat_uf", uf, 0);

        // Full
        do_reset();
        iv = 1'b1;
        for (int i = 0; i < 8; i++) begin
            id = 8'h10 + 8'(i);
            tick();
        end
        chk("full_lvl8", lvl, 8);
        chk("full_rdy", rdy, 0);
        id = 8'hEE; tick();
        chk("full_lvl9", lvl, 8);
        chk("full_hold", de, 0);
        iv = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("full_out", dd, 32'h10 + 32'(i));
            if (i == 0) chk("full_rdy1", rdy, 1);
        end
        chk("full_lvl0", lvl, 0);
        chk("full_en", de, 1);

        // Underflow and return to IDLE
        do_reset();
        en = 1'b1;
        iv = 1'b1; id = 8'h5A; tick();
        id = 8'hC3; tick();
        chk("uf_w0", dd, 8'h5A);
        chk("uf_pre", uf, 0);
        iv = 1'b0; tick();
        chk("uf_w1", dd, 8'hC3);
        chk("uf_pre2", uf, 0);
        tick();
        chk("uf_idle_d", dd, 8'h00);
        chk("uf_en1", de, 1);
        chk("uf_set", uf, 1);
        tick();
        chk("uf_en0", de, 0);
        chk("uf_d0", dd, 8'h00);
        tick();
        chk("uf_sticky", uf, 1);
        chk("uf_stay", de, 0);

        // Training
        do_reset();
        en = 1'b1;
        tr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            iv = (i >= 2 && i < 5);
            id = 8'h71 + 8'(i - 2);
            tick();
            chk("trn_d", dd, 8'h55);
            chk("trn_flag", trn, 1);
        end
        iv = 1'b0;
        chk("trn_en", de, 1);
        chk("trn_lvl", lvl, 3);
        tr = 1'b0; tick();
        chk("trn_off", trn, 0);
        chk("trn_w0", dd, 8'h71);
        tick();
        chk("trn_w1", dd, 8'h72);
        tick();
        chk("trn_w2", dd, 8'h73);
        chk("trn_lvl0", lvl, 0);

        // Enable freeze
        do_reset();
        iv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            id = 8'h81 + 8'(i);
            tick();
        end
        iv = 1'b0;
        en = 1'b1; tick();
        chk("frz_w0", dd, 8'h81);
        chk("frz_lvl3", lvl, 3);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iv = (i < 2);
            id = 8'h85 + 8'(i);
            tick();
            chk("frz_hold", dd, 8'h81);
            chk("frz_en", de, 1);
            chk("frz_lvl", lvl, (i == 0) ? 4 : 5);
        end
        iv = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("frz_out", dd, 32'h82 + 32'(i));
        end
        chk("frz_lvl0", lvl, 0);

        // Reset mid-stream at level 5
        do_reset();
        iv = 1'b1;
        for (int i = 0; i < 6; i++) begin
            id = 8'hB0 + 8'(i);
            tick();
        end
        iv = 1'b0;
        en = 1'b1; tick();
        chk("mid_w0", dd, 8'hB0);
        chk("mid_lvl5", lvl, 5);
        rst_n = 1'b0;
        #1;
        chk("mid_d", dd, 0);
        chk("mid_en", de, 0);
        chk("mid_lvl", lvl, 0);
        chk("mid_uf", uf, 0);
        chk("mid_rdy", rdy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_idle", de, 0);
        chk("mid_lvl_after", lvl, 0);
        chk("mid_rdy1", rdy, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
